// File: rtl/boron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boron_pkg
//  Description : Shared constants and FSM state encoding for the BORON
//                iterative round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package boron_pkg;

    localparam int BLOCK_W = 64;
    localparam int ROUNDS  = 25;
    localparam int CNT_W   = 5;

    // Sequencer states, explicitly 2 bits wide with fixed encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/boron_round_counter.sv
`default_nettype none
// ============================================================================
//  Module      : boron_round_counter
//  Description : Round counter for the BORON sequencer. Loads 1 on block
//                accept, increments once per round, saturates at ROUNDS and
//                flags the terminal round.
//  Revision    : 1.0 - initial release
// ============================================================================
module boron_round_counter
    import boron_pkg::*;
#(
    parameter int ROUNDS = boron_pkg::ROUNDS,
    parameter int CNT_W  = boron_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load_one,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(ROUNDS);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == c_last);
    assign o_terminal = w_terminal;
    assign o_count    = r_count;

    // Clear wins over load, load over increment; never counts past ROUNDS.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_load_one) begin
            r_count <= CNT_W'(1);
        end else if (i_inc && !w_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boron_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boron_round_ctrl
//  Description : Iterative sequencer for the 64-bit BORON cipher. Holds the
//                cipher state, steps the external round logic and key
//                schedule for ROUNDS cycles, applies the final whitening key
//                and holds the ciphertext until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module boron_round_ctrl
    import boron_pkg::*;
#(
    parameter int DATA_W = boron_pkg::BLOCK_W,
    parameter int ROUNDS = boron_pkg::ROUNDS,
    parameter int CNT_W  = boron_pkg::CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pt,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_state,
    input  logic [DATA_W-1:0] i_round_out,
    input  logic [DATA_W-1:0] i_rk,
    output logic              o_key_load,
    output logic              o_key_step,
    output logic [CNT_W-1:0]  o_round_cnt,
    output logic [DATA_W-1:0] o_ct,
    output logic              o_valid,
    input  logic              i_ack
);

    fsm_state_t        r_fsm;
    fsm_state_t        w_fsm_next;
    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] r_ct;
    logic              r_valid;
    logic              w_accept;
    logic              w_cnt_clear;
    logic              w_cnt_inc;
    logic              w_terminal;

    assign o_state = r_state;
    assign o_ct    = r_ct;
    assign o_valid = r_valid;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state decode and handshake / key-schedule controls.
    always_comb begin
        w_fsm_next  = r_fsm;
        o_ready     = 1'b0;
        o_key_step  = 1'b0;
        w_accept    = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_fsm)
            IDLE: begin
                o_ready  = 1'b1;
                w_accept = i_start;
                if (i_start) begin
                    w_fsm_next = RUN;
                end
            end
            RUN: begin
                o_key_step = 1'b1;
                if (w_terminal) begin
                    w_cnt_clear = 1'b1;
                    w_fsm_next  = FINAL;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            FINAL: begin
                w_fsm_next = DONE;
            end
            DONE: begin
                if (i_ack) begin
                    w_fsm_next = IDLE;
                end
            end
            default: begin
                w_fsm_next = IDLE;
            end
        endcase
        o_key_load = w_accept;
    end

    // Cipher state and ciphertext/valid output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= '0;
            r_ct    <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= i_pt;
                    end
                end
                RUN: begin
                    r_state <= i_round_out;
                end
                FINAL: begin
                    r_ct    <= r_state ^ i_rk;
                    r_valid <= 1'b1;
                end
                DONE: begin
                    if (i_ack) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    boron_round_counter #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) u_round_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_cnt_clear),
        .i_load_one (w_accept),
        .i_inc      (w_cnt_inc),
        .o_count    (o_round_cnt),
        .o_terminal (w_terminal)
    );

endmodule
`default_nettype wire

// File: tb/tb_boron_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boron_round_ctrl
//  Description : Directed self-checking bench for boron_round_ctrl. The round
//                logic is modelled as state+1 and the round key as a
//                bench-driven constant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boron_round_ctrl;
    import boron_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] pt;
    logic [63:0] rk;
    logic        ack;
    logic        ready;
    logic [63:0] state;
    logic [63:0] round_out;
    logic        key_load;
    logic        key_step;
    logic [4:0]  cnt;
    logic [63:0] ct;
    logic        valid;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int busy_cnt = 0;
    int edge_a;
    int busy_a;

    always #5 clk = ~clk;

    assign round_out = state + 64'd1;

    // Edge counter for accept-to-accept spacing.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Count cycles in which the controller is busy.
    always @(negedge clk) if (!rst && !ready) busy_cnt <= busy_cnt + 1;

    boron_round_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_pt        (pt),
        .o_ready     (ready),
        .o_state     (state),
        .i_round_out (round_out),
        .i_rk        (rk),
        .o_key_load  (key_load),
        .o_key_step  (key_step),
        .o_round_cnt (cnt),
        .o_ct        (ct),
        .o_valid     (valid),
        .i_ack       (ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},    ready,    64'd1);
        chk({tag, "_valid"},    valid,    64'd0);
        chk({tag, "_ct"},       ct,       64'd0);
        chk({tag, "_cnt"},      cnt,      64'd0);
        chk({tag, "_key_step"}, key_step, 64'd0);
        chk({tag, "_key_load"}, key_load, 64'd0);
        chk({tag, "_state"},    state,    64'd0);
    endtask

    // Present a block in IDLE and take the accept edge.
    task automatic accept(input logic [63:0] p);
        pt    = p;
        start = 1'b1;
        #1;
        chk("accept_ready", ready, 64'd1);
        chk("accept_key_load", key_load, 64'd1);
        step();
        start = 1'b0;
        chk("accept_state", state, p);
    endtask

    // From just after the accept edge up to the first valid cycle.
    task automatic run_to_valid(input logic [63:0] exp_ct);
        for (int k = 1; k <= 25; k++) begin
            chk("run_cnt", cnt, 64'(k));
            chk("run_key_step", key_step, 64'd1);
            chk("run_key_load", key_load, 64'd0);
            chk("run_ready", ready, 64'd0);
            chk("run_valid", valid, 64'd0);
            step();
        end
        chk("final_cnt", cnt, 64'd0);
        chk("final_key_step", key_step, 64'd0);
        chk("final_valid", valid, 64'd0);
        step();
        chk("done_valid", valid, 64'd1);
        chk("done_ct", ct, exp_ct);
        chk("done_cnt", cnt, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pt    = 64'd0;
        rk    = 64'd0;
        ack   = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_reset_vals("idle");
        end

        // Basic block, ack tied high: 0x10 + 25 rounds of +1 = 0x29.
        ack = 1'b1;
        accept(64'h0000_0000_0000_0010);
        run_to_valid(64'h29);
        step();
        chk("ack1_valid", valid, 64'd0);
        chk("ack1_ready", ready, 64'd1);

        // Whitening key applied, ack delayed by 10 cycles.
        ack = 1'b0;
        rk  = 64'hFFFF_0000_FFFF_0000;
        accept(64'h0000_0000_0000_0010);
        run_to_valid(64'hFFFF_0000_FFFF_0029);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("hold_valid", valid, 64'd1);
            chk("hold_ct", ct, 64'hFFFF_0000_FFFF_0029);
            chk("hold_ready", ready, 64'd0);
        end
        ack = 1'b1;
        step();
        chk("late_ack_valid", valid, 64'd0);
        chk("late_ack_ready", ready, 64'd1);
        rk = 64'd0;

        // i_start pulses during RUN (round 7) and DONE are ignored.
        ack = 1'b0;
        accept(64'h0000_0000_0000_0010);
        for (int k = 1; k <= 25; k++) begin
            chk("busy_cnt_seq", cnt, 64'(k));
            if (k == 7) begin
                start = 1'b1;
                #1;
                chk("run_start_key_load", key_load, 64'd0);
            end
            step();
            start = 1'b0;
        end
        chk("busy_final_cnt", cnt, 64'd0);
        step();
        chk("busy_done_valid", valid, 64'd1);
        chk("busy_done_ct", ct, 64'h29);
        start = 1'b1;
        #1;
        chk("done_start_key_load", key_load, 64'd0);
        step();
        start = 1'b0;
        chk("done_start_valid", valid, 64'd1);
        chk("done_start_ready", ready, 64'd0);
        chk("done_start_cnt", cnt, 64'd0);
        ack = 1'b1;
        step();
        chk("busy_ack_valid", valid, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("one_result_valid", valid, 64'd0);
            chk("one_result_ready", ready, 64'd1);
            chk("one_result_key_step", key_step, 64'd0);
        end

        // Reset mid-RUN at round 12 discards the block.
        accept(64'h0000_0000_0000_0010);
        for (int k = 1; k < 12; k++) step();
        chk("pre_reset_cnt", cnt, 64'd12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("mid_reset");
        accept(64'd0);
        run_to_valid(64'h19);
        step();
        chk("post_reset_ready", ready, 64'd1);

        // Back-to-back: ack in first DONE cycle, start asserted right after.
        // Busy span is RUN(25)+FINAL+DONE = 27 cycles; the ack edge itself
        // returns to IDLE, so the next accept edge is 28 edges after the first.
        accept(64'h0000_0000_0000_0100);
        edge_a = edge_cnt;
        busy_a = busy_cnt;
        run_to_valid(64'h119);
        pt    = 64'h0000_0000_0000_0200;
        start = 1'b1;
        #1;
        chk("b2b_done_key_load", key_load, 64'd0);
        step();
        chk("b2b_ready", ready, 64'd1);
        chk("b2b_key_load", key_load, 64'd1);
        step();
        start = 1'b0;
        chk("b2b_accept_cnt", cnt, 64'd1);
        chk("b2b_accept_state", state, 64'h200);
        chk("b2b_busy_cycles", 64'(busy_cnt - busy_a), 64'd27);
        chk("b2b_edge_spacing", 64'(edge_cnt - edge_a), 64'd28);
        run_to_valid(64'h219);
        step();
        chk("b2b_end_ready", ready, 64'd1);
        chk("b2b_end_valid", valid, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
